// File: rtl/parity_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : parity_frame_ctrl
// Purpose  : Accepts parallel words over valid/ready and serialises each one
//            LSB-first, followed by a parity bit that closes the frame.
//            Supports downstream back-pressure and frame abort.
// Options  : `define FRAME_CNT_EN adds a 16-bit completed-frame counter output.
// Revision : 1.0 - initial release
// ============================================================================
module parity_frame_ctrl #(
  parameter int DATA_W = 8,    // data bits per frame (2..32)
  parameter bit ODD    = 1'b0  // 0 = even parity bit, 1 = odd parity bit
) (
  input  logic              clock,
  input  logic              reset,      // asynchronous, active-low
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              ser_ready,
  input  logic              abort,
  output logic              ser_bit,
  output logic              ser_valid,
  output logic              ser_last,
  output logic              busy
`ifdef FRAME_CNT_EN
  ,
  output logic [15:0]       frame_cnt
`endif
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] C_LAST_IDX = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_PAR   = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_shreg;
  logic [DATA_W-1:0] w_shreg_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              r_acc;
  logic              w_acc_nxt;
  logic              w_par_done;

  // State, shift register, bit counter and parity accumulator
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_shreg <= '0;
      r_cnt   <= '0;
      r_acc   <= ODD;
    end else begin
      r_state <= w_state_nxt;
      r_shreg <= w_shreg_nxt;
      r_cnt   <= w_cnt_nxt;
      r_acc   <= w_acc_nxt;
    end
  end

  // Next-state and serial output decode; abort always wins over progress
  always_comb begin
    w_state_nxt = r_state;
    w_shreg_nxt = r_shreg;
    w_cnt_nxt   = r_cnt;
    w_acc_nxt   = r_acc;
    w_par_done  = 1'b0;
    ser_bit     = 1'b0;
    ser_valid   = 1'b0;
    ser_last    = 1'b0;
    busy        = 1'b0;

    case (r_state)
      ST_IDLE: begin
        // No serial bit in the accept cycle; the first data bit appears next.
        if (in_valid && !abort) begin
          w_state_nxt = ST_SHIFT;
          w_shreg_nxt = in_data;
          w_cnt_nxt   = '0;
          w_acc_nxt   = ODD;
        end
      end

      ST_SHIFT: begin
        ser_valid = 1'b1;
        ser_bit   = r_shreg[0];
        busy      = 1'b1;
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else if (ser_ready) begin
          w_acc_nxt   = r_acc ^ r_shreg[0];
          w_shreg_nxt = {1'b0, r_shreg[DATA_W-1:1]};
          if (r_cnt == C_LAST_IDX) begin
            w_state_nxt = ST_PAR;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end

      ST_PAR: begin
        ser_valid = 1'b1;
        ser_last  = 1'b1;
        ser_bit   = r_acc;
        busy      = 1'b1;
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else if (ser_ready) begin
          w_state_nxt = ST_IDLE;
          w_par_done  = 1'b1;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Gated by the reset pin so the producer never sees ready during reset
  assign in_ready = (r_state == ST_IDLE) && reset;

`ifdef FRAME_CNT_EN
  logic [15:0] r_frame_cnt;

  // Count frames whose parity bit was accepted; wraps naturally at 16 bits
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_frame_cnt <= 16'h0000;
    end else if (w_par_done) begin
      r_frame_cnt <= r_frame_cnt + 16'h0001;
    end
  end

  assign frame_cnt = r_frame_cnt;
`else
  logic w_unused_par_done;
  assign w_unused_par_done = w_par_done;
`endif

endmodule
`default_nettype wire

// File: tb/tb_parity_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_parity_frame_ctrl
// Purpose  : Directed self-checking bench for parity_frame_ctrl. Two DUTs
//            share stimulus: u_even (ODD=0) and u_odd (ODD=1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_parity_frame_ctrl;

  logic       clock;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       ser_ready;
  logic       abort;

  logic e_in_ready, e_ser_bit, e_ser_valid, e_ser_last, e_busy;
  logic o_in_ready, o_ser_bit, o_ser_valid, o_ser_last, o_busy;
`ifdef FRAME_CNT_EN
  logic [15:0] e_frame_cnt, o_frame_cnt;
`endif

  int total = 0;
  int bad   = 0;

  parity_frame_ctrl #(.DATA_W(8), .ODD(1'b0)) u_even (
    .clock     (clock),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (e_in_ready),
    .ser_ready (ser_ready),
    .abort     (abort),
    .ser_bit   (e_ser_bit),
    .ser_valid (e_ser_valid),
    .ser_last  (e_ser_last),
    .busy      (e_busy)
`ifdef FRAME_CNT_EN
    ,
    .frame_cnt (e_frame_cnt)
`endif
  );

  parity_frame_ctrl #(.DATA_W(8), .ODD(1'b1)) u_odd (
    .clock     (clock),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (o_in_ready),
    .ser_ready (ser_ready),
    .abort     (abort),
    .ser_bit   (o_ser_bit),
    .ser_valid (o_ser_valid),
    .ser_last  (o_ser_last),
    .busy      (o_busy)
`ifdef FRAME_CNT_EN
    ,
    .frame_cnt (o_frame_cnt)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Watchdog: the bench must always terminate
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present a word for one edge, then scramble in_data to prove it is not re-sampled
  task automatic accept(input logic [7:0] d);
    in_data  = d;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_data  = ~d;
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b0; ser_ready = 1'b1; abort = 1'b0; in_data = 8'h00;
    #3;
    total++;
    if ({e_in_ready, e_ser_bit, e_ser_valid, e_ser_last, e_busy, o_in_ready, o_ser_valid} !== 7'b0) begin
      bad++;
      $display("FAIL reset_outputs: got rdy=%b bit=%b vld=%b last=%b busy=%b ordy=%b ovld=%b want all 0",
               e_in_ready, e_ser_bit, e_ser_valid, e_ser_last, e_busy, o_in_ready, o_ser_valid);
    end
    @(negedge clock);
    reset = 1'b1;
    tick();
    total++;
    if (e_in_ready !== 1'b1 || e_ser_valid !== 1'b0 || e_busy !== 1'b0 || o_in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_release: got rdy=%b vld=%b busy=%b ordy=%b want 1 0 0 1",
               e_in_ready, e_ser_valid, e_busy, o_in_ready);
    end
  endtask

  task automatic test_basic_a5();
    int exp_bits[8] = '{1, 0, 1, 0, 0, 1, 0, 1};
    int cyc = 0;
    accept(8'hA5); cyc++;
    for (int i = 0; i < 8; i++) begin
      total++;
      if (e_ser_valid !== 1'b1 || e_ser_last !== 1'b0 || e_busy !== 1'b1 || e_in_ready !== 1'b0 ||
          e_ser_bit !== exp_bits[i][0]) begin
        bad++;
        $display("FAIL basic_bit%0d: got bit=%b vld=%b last=%b busy=%b rdy=%b want bit=%0d vld=1 last=0 busy=1 rdy=0",
                 i, e_ser_bit, e_ser_valid, e_ser_last, e_busy, e_in_ready, exp_bits[i]);
      end
      tick(); cyc++;
    end
    total++;
    if (e_ser_last !== 1'b1 || e_ser_valid !== 1'b1 || e_ser_bit !== 1'b0 || o_ser_bit !== 1'b1) begin
      bad++;
      $display("FAIL basic_parity: got last=%b vld=%b even=%b odd=%b want 1 1 0 1",
               e_ser_last, e_ser_valid, e_ser_bit, o_ser_bit);
    end
    tick(); cyc++;
    total++;
    if (e_in_ready !== 1'b1 || e_ser_valid !== 1'b0 || e_ser_last !== 1'b0 || e_busy !== 1'b0 || cyc != 10) begin
      bad++;
      $display("FAIL basic_end: got rdy=%b vld=%b last=%b busy=%b period=%0d want 1 0 0 0 period=10",
               e_in_ready, e_ser_valid, e_ser_last, e_busy, cyc);
    end
  endtask

  task automatic test_odd_parity();
    int exp_bits[8] = '{1, 1, 1, 0, 0, 0, 0, 0};
    accept(8'h07);
    for (int i = 0; i < 8; i++) begin
      total++;
      if (o_ser_valid !== 1'b1 || o_ser_bit !== exp_bits[i][0] || e_ser_bit !== exp_bits[i][0]) begin
        bad++;
        $display("FAIL odd_bit%0d: got odd=%b even=%b vld=%b want %0d vld=1",
                 i, o_ser_bit, e_ser_bit, o_ser_valid, exp_bits[i]);
      end
      tick();
    end
    total++;
    if (o_ser_last !== 1'b1 || o_ser_bit !== 1'b0 || e_ser_last !== 1'b1 || e_ser_bit !== 1'b1) begin
      bad++;
      $display("FAIL odd_parity: got odd last=%b bit=%b even last=%b bit=%b want 1 0 1 1",
               o_ser_last, o_ser_bit, e_ser_last, e_ser_bit);
    end
    tick();
  endtask

  task automatic test_backpressure();
    int exp_bits[8] = '{0, 0, 1, 1, 1, 1, 0, 0};
    int cyc = 0;
    accept(8'h3C); cyc++;
    for (int i = 0; i < 8; i++) begin
      total++;
      if (e_ser_valid !== 1'b1 || e_ser_bit !== exp_bits[i][0]) begin
        bad++;
        $display("FAIL bp_bit%0d: got bit=%b vld=%b want %0d vld=1", i, e_ser_bit, e_ser_valid, exp_bits[i]);
      end
      if (i == 2) begin
        ser_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          tick(); cyc++;
          total++;
          if (e_ser_valid !== 1'b1 || e_ser_bit !== 1'b1 || e_ser_last !== 1'b0) begin
            bad++;
            $display("FAIL bp_hold%0d: got bit=%b vld=%b last=%b want 1 1 0", s, e_ser_bit, e_ser_valid, e_ser_last);
          end
        end
        ser_ready = 1'b1;
      end
      tick(); cyc++;
    end
    total++;
    if (e_ser_last !== 1'b1 || e_ser_bit !== 1'b0) begin
      bad++;
      $display("FAIL bp_parity: got last=%b bit=%b want 1 0", e_ser_last, e_ser_bit);
    end
    tick(); cyc++;
    total++;
    if (e_in_ready !== 1'b1 || cyc != 13) begin
      bad++;
      $display("FAIL bp_period: got rdy=%b period=%0d want rdy=1 period=13", e_in_ready, cyc);
    end
  endtask

  task automatic test_abort();
    int exp_bits[8] = '{1, 0, 0, 0, 0, 0, 0, 0};
    accept(8'hFF);
    for (int i = 0; i < 4; i++) tick();
    total++;
    if (e_ser_valid !== 1'b1 || e_ser_bit !== 1'b1) begin
      bad++;
      $display("FAIL abort_pre: got bit=%b vld=%b want 1 1", e_ser_bit, e_ser_valid);
    end
    abort = 1'b1;
    tick();
    total++;
    if (e_ser_valid !== 1'b0 || e_ser_last !== 1'b0 || e_busy !== 1'b0 || e_in_ready !== 1'b1) begin
      bad++;
      $display("FAIL abort_drop: got vld=%b last=%b busy=%b rdy=%b want 0 0 0 1",
               e_ser_valid, e_ser_last, e_busy, e_in_ready);
    end
    // abort in IDLE must block acceptance
    in_data = 8'h55; in_valid = 1'b1;
    tick();
    total++;
    if (e_ser_valid !== 1'b0 || e_busy !== 1'b0 || e_in_ready !== 1'b1) begin
      bad++;
      $display("FAIL abort_idle_block: got vld=%b busy=%b rdy=%b want 0 0 1", e_ser_valid, e_busy, e_in_ready);
    end
    in_valid = 1'b0; abort = 1'b0;
    accept(8'h01);
    for (int i = 0; i < 8; i++) begin
      total++;
      if (e_ser_valid !== 1'b1 || e_ser_bit !== exp_bits[i][0] || e_ser_last !== 1'b0) begin
        bad++;
        $display("FAIL abort_next_bit%0d: got bit=%b vld=%b last=%b want %0d 1 0",
                 i, e_ser_bit, e_ser_valid, e_ser_last, exp_bits[i]);
      end
      tick();
    end
    total++;
    if (e_ser_last !== 1'b1 || e_ser_bit !== 1'b1 || o_ser_bit !== 1'b0) begin
      bad++;
      $display("FAIL abort_next_parity: got last=%b even=%b odd=%b want 1 1 0", e_ser_last, e_ser_bit, o_ser_bit);
    end
    tick();
  endtask

  task automatic test_async_reset();
    int exp_bits[8] = '{1, 1, 1, 1, 0, 0, 0, 0};
    accept(8'hA5);
    for (int i = 0; i < 3; i++) tick();
    #2;
    reset = 1'b0;
    #1;
    total++;
    if (e_ser_valid !== 1'b0 || e_busy !== 1'b0 || e_in_ready !== 1'b0 || o_ser_valid !== 1'b0 || o_busy !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: got vld=%b busy=%b rdy=%b ovld=%b obusy=%b want all 0",
               e_ser_valid, e_busy, e_in_ready, o_ser_valid, o_busy);
    end
    @(negedge clock);
    reset = 1'b1;
    tick();
    total++;
    if (e_in_ready !== 1'b1 || e_ser_valid !== 1'b0) begin
      bad++;
      $display("FAIL async_release: got rdy=%b vld=%b want 1 0", e_in_ready, e_ser_valid);
    end
    accept(8'h0F);
    for (int i = 0; i < 8; i++) begin
      total++;
      if (e_ser_valid !== 1'b1 || e_ser_bit !== exp_bits[i][0]) begin
        bad++;
        $display("FAIL async_clean_bit%0d: got bit=%b vld=%b want %0d 1", i, e_ser_bit, e_ser_valid, exp_bits[i]);
      end
      tick();
    end
    total++;
    if (e_ser_last !== 1'b1 || e_ser_bit !== 1'b0 || o_ser_bit !== 1'b1) begin
      bad++;
      $display("FAIL async_clean_parity: got last=%b even=%b odd=%b want 1 0 1", e_ser_last, e_ser_bit, o_ser_bit);
    end
    tick();
  endtask

`ifdef FRAME_CNT_EN
  task automatic test_frame_cnt();
    @(negedge clock);
    reset = 1'b0;
    #1;
    total++;
    if (e_frame_cnt !== 16'h0000 || o_frame_cnt !== 16'h0000) begin
      bad++;
      $display("FAIL fcnt_reset: got %h %h want 0000", e_frame_cnt, o_frame_cnt);
    end
    @(negedge clock);
    reset = 1'b1;
    tick();
    for (int f = 0; f < 3; f++) begin
      accept(8'hC3);
      for (int i = 0; i < 9; i++) tick();
    end
    accept(8'h81);
    tick(); tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
    total++;
    if (e_frame_cnt !== 16'd3 || o_frame_cnt !== 16'd3) begin
      bad++;
      $display("FAIL fcnt_three: got %0d %0d want 3", e_frame_cnt, o_frame_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_a5();
    test_odd_parity();
    test_backpressure();
    test_abort();
    test_async_reset();
`ifdef FRAME_CNT_EN
    test_frame_cnt();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
